// File: rtl/mem_pkg.sv
// Shared types and constants for the RV32I memory-access stage.
`timescale 1ns/1ps
package mem_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsigned variants only exist for loads; every unknown code is a word.
  function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
    size_e sz;
    sz = SZ_W;
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) sz = SZ_B;
    else if (f3 == F3_H || (!is_store && f3 == F3_HU)) sz = SZ_H;
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane select and sign/zero extension of the data-memory read word.
`timescale 1ns/1ps
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'd0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'd0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data-memory access, upstream stall and the MEM/WB register.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module mem_stage
  import mem_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      store_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [REG_W-1:0] addr_rd_in,
  input  logic [1:0]       select_mux_2_in,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_valid,
  output logic [31:0]      mem_out,
  output logic [31:0]      alu_out,
  output logic [REG_W-1:0] addr_rd,
  output logic [1:0]       select_mux_2,
  output logic             misaligned
);

  // state    | meaning
  // S_IDLE   | accept a new instruction from EX/MEM
  // S_ACCESS | request outstanding, waiting for dmem_ack

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [2:0]         f3_q, f3_d;
  logic               we_q, we_d;
  logic [REG_W-1:0]   rd_q, rd_d, addr_rd_q, addr_rd_d;
  logic [1:0]         sel_q, sel_d, sel_out_q, sel_out_d;
  logic               wb_valid_q, wb_valid_d, mis_q, mis_d;
  logic [31:0]        mem_out_q, mem_out_d, alu_out_q, alu_out_d;

  logic               is_mem, mis_in;
  size_e              sz_in;
  logic [31:0]        wdata_in, load_val;
  logic [3:0]         wstrb_in;

  assign is_mem = mem_read | mem_write;
  assign sz_in  = access_size(funct3, mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_in = is_mem & (((sz_in == SZ_H) & alu_result[0]) |
                            ((sz_in == SZ_W) & (alu_result[1:0] != 2'b00)));
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    case (sz_in)
      SZ_B: begin
        wdata_in = {4{store_data[7:0]}};
        wstrb_in = STRB_B << alu_result[1:0];
      end
      SZ_H: begin
        wdata_in = {2{store_data[15:0]}};
        wstrb_in = STRB_H << {alu_result[1], 1'b0};
      end
      default: begin
        wdata_in = store_data;
        wstrb_in = STRB_W;
      end
    endcase
  end

  mem_load_align u_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (load_val)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    we_d       = we_q;
    rd_d       = rd_q;
    sel_d      = sel_q;
    wb_valid_d = 1'b0;
    mis_d      = 1'b0;
    mem_out_d  = mem_out_q;
    alu_out_d  = alu_out_q;
    addr_rd_d  = addr_rd_q;
    sel_out_d  = sel_out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem || mis_in) begin
            wb_valid_d = 1'b1;
            mem_out_d  = 32'd0;
            alu_out_d  = alu_result;
            addr_rd_d  = mis_in ? '0 : addr_rd_in;
            sel_out_d  = select_mux_2_in;
            mis_d      = mis_in;
          end else begin
            addr_d  = alu_result;
            wdata_d = wdata_in;
            wstrb_d = wstrb_in;
            f3_d    = funct3;
            we_d    = mem_write;
            rd_d    = addr_rd_in;
            sel_d   = select_mux_2_in;
            state_d = S_ACCESS;
          end
        end
      end
      default: begin
        if (dmem_ack) begin
          wb_valid_d = 1'b1;
          mem_out_d  = we_q ? 32'd0 : load_val;
          alu_out_d  = addr_q;
          addr_rd_d  = rd_q;
          sel_out_d  = sel_q;
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      sel_q      <= '0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      mem_out_q  <= '0;
      alu_out_q  <= '0;
      addr_rd_q  <= '0;
      sel_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      f3_q       <= f3_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      mem_out_q  <= mem_out_d;
      alu_out_q  <= alu_out_d;
      addr_rd_q  <= addr_rd_d;
      sel_out_q  <= sel_out_d;
    end
  end

  // Stall is forced low during reset so upstream is released with the request.
  assign stall = !rst & (((state_q == S_IDLE) & in_valid & is_mem & !mis_in) |
                         ((state_q == S_ACCESS) & !dmem_ack));

  assign dmem_req     = (state_q == S_ACCESS);
  assign dmem_we      = dmem_req & we_q;
  assign dmem_addr    = {addr_q[31:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = dmem_req ? wstrb_q : 4'b0000;
  assign wb_valid     = wb_valid_q;
  assign mem_out      = mem_out_q;
  assign alu_out      = alu_out_q;
  assign addr_rd      = addr_rd_q;
  assign select_mux_2 = sel_out_q;
  assign misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writebacks plus handshake checks.
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  addr_rd_in = '0;
  logic [1:0]  select_mux_2_in = '0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] mem_out, alu_out;
  logic [4:0]  addr_rd;
  logic [1:0]  select_mux_2;
  logic        misaligned;

  mem_stage #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr_rd_in(addr_rd_in), .select_mux_2_in(select_mux_2_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .mem_out(mem_out),
    .alu_out(alu_out), .addr_rd(addr_rd), .select_mux_2(select_mux_2),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        mis;
  } wb_t;

  wb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  int  req_edges = 0;
  logic prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Writeback monitor: every wb_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (dmem_req && !prev_req) req_edges++;
      prev_req = dmem_req;
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          wb_t e;
          e = sb_q.pop_front();
          check("wb_mem_out", mem_out, e.mem);
          check("wb_alu_out", alu_out, e.alu);
          check("wb_addr_rd", {27'd0, addr_rd}, {27'd0, e.rd});
          check("wb_sel", {30'd0, select_mux_2}, {30'd0, e.sel});
          check("wb_misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        end
      end
    end
  end

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic [1:0] sel);
    @(posedge clk); #1;
    in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = alu; addr_rd_in = rd; select_mux_2_in = sel; funct3 = 3'b000;
    sb_q.push_back('{mem: 32'd0, alu: alu, rd: rd, sel: sel, mis: 1'b0});
    @(negedge clk);
    check("alu_stall", {31'd0, stall}, 32'd0);
    check("alu_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mem_op(input string tag, input logic is_st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int waits,
                        input logic [31:0] exp_mem, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [4:0] rd,
                        input logic [1:0] sel);
    int stall_cnt;
    int edges0;
    stall_cnt = 0;
    edges0 = req_edges;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_read = !is_st; mem_write = is_st; funct3 = f3;
    alu_result = addr; store_data = sdata; addr_rd_in = rd; select_mux_2_in = sel;
    sb_q.push_back('{mem: exp_mem, alu: addr, rd: rd, sel: sel, mis: 1'b0});
    @(negedge clk);
    check({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "_accept_noreq"}, {31'd0, dmem_req}, 32'd0);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      dmem_ack = (w == waits);
      dmem_rdata = rdata;
      @(negedge clk);
      check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, is_st});
      if (is_st) begin
        check({tag, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_req_dropped"}, {31'd0, dmem_req}, 32'd0);
    check({tag, "_stall_cycles"}, stall_cnt, waits + 1);
    check({tag, "_one_request"}, req_edges - edges0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_mem_out", mem_out, 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_addr_rd", {27'd0, addr_rd}, 32'd0);
    check("rst_sel", {30'd0, select_mux_2}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    alu_op(32'h5555_5555, 5'b10101, 2'b01);
    alu_op(32'h0000_0007, 5'b00011, 2'b10);

    mem_op("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hAAAA_AAAA, 3,
           32'hAAAA_AAAA, 4'h0, 32'h0, 5'd1, 2'b00);
    mem_op("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
           32'hFFFF_FF80, 4'h0, 32'h0, 5'd2, 2'b00);
    mem_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1,
           32'h0000_0080, 4'h0, 32'h0, 5'd3, 2'b00);
    mem_op("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0,
           32'hFFFF_80FF, 4'h0, 32'h0, 5'd4, 2'b00);
    mem_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 0,
           32'h0000_80FF, 4'h0, 32'h0, 5'd5, 2'b00);
    mem_op("sh",  1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'hFFFF_FFFF, 1,
           32'h0, 4'b1100, 32'hBEEF_BEEF, 5'd6, 2'b11);
    mem_op("sb",  1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 0,
           32'h0, 4'b0010, 32'hA5A5_A5A5, 5'd7, 2'b00);
    mem_op("sw",  1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 32'h0, 2,
           32'h0, 4'b1111, 32'hDEAD_BEEF, 5'd8, 2'b00);
    alu_op(32'h1234_5678, 5'd9, 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
    begin
      int edges0;
      edges0 = req_edges;
      @(posedge clk); #1;
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
      alu_result = 32'h101; addr_rd_in = 5'd7; select_mux_2_in = 2'b01;
      sb_q.push_back('{mem: 32'd0, alu: 32'h101, rd: 5'd0, sel: 2'b01, mis: 1'b1});
      @(negedge clk);
      check("mis_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      check("mis_noreq", {31'd0, dmem_req}, 32'd0);
      check("mis_req_edges", req_edges - edges0, 32'd0);
    end
`else
    mem_op("lw_unal", 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0,
           32'h1122_3344, 4'h0, 32'h0, 5'd10, 2'b00);
    check("no_misalign_flag", {31'd0, misaligned}, 32'd0);
`endif

    // Reset while a load is outstanding, then a stray ack.
    @(posedge clk); #1;
    in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h300;
    addr_rd_in = 5'd11;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("rstmid_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_req", {31'd0, dmem_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_req", {31'd0, dmem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_wb", {31'd0, wb_valid}, 32'd0);

    alu_op(32'hA5A5_0001, 5'd12, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
